fork_join_engine: RTL and testbench
===================================

# fork_join_engine

Parametrised, clocked fork/join dispatcher for the SemanticFacts block set. It generalises the fixed three-lane fork/join demonstrator to CHANNELS lanes, each with a programmable completion latency. It supports four completion modes: sequential, join-all, join-any and join-none. On an accepted start it captures one operand, runs every lane, reports per-lane results and valid flags, and emits a single done pulse at the point the selected join semantics dictate.

## Interface
- WIDTH, 8: operand and per-lane result width.
- CHANNELS, 4: number of parallel lanes, 1..WIDTH.
- LAT_W, 4: width of each per-lane latency field.
- clk  in  1: clock; all state changes on the rising edge.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: start request; sampled every edge.
- mode  in  2: completion mode. 0 = SEQ, 1 = JOIN_ALL, 2 = JOIN_ANY, 3 = JOIN_NONE. Captured on an accepted start.
- data_in  in  WIDTH: operand, captured on an accepted start.
- lat_in  in  CHANNELS*LAT_W: latency of lane i in bits [i*LAT_W +: LAT_W], captured on an accepted start.
- busy  out  1: high while any lane is still running.
- done  out  1: one-cycle pulse marking the join point.
- first_id  out  clog2(CHANNELS), minimum 1: lane that satisfied JOIN_ANY; updated only in that mode.
- ch_valid  out  CHANNELS: bit i is high once lane i has completed for the current run.
- result  out  CHANNELS*WIDTH: lane i result in bits [i*WIDTH +: WIDTH].
- start_err  out  1: one-cycle pulse when start arrives while busy.

## Operation
- Reset values: busy=0, done=0, start_err=0, first_id=0, ch_valid=0, result=0. Internal state is IDLE.
- Reset is asynchronous. Asserting it mid-run aborts all lanes immediately. No done pulse follows.
- Lane function: result_i = (data_in + (1 << i)) mod 2^WIDTH. The value is written at the lane's completion edge only.
- Effective latency: L_i = lat_in field, with 0 treated as 1. Range is 1..2^LAT_W-1.
- Accepted start (start=1 and busy=0):
  - captures mode, data_in and L_i;
  - clears ch_valid;
  - sets busy;
  - results keep their old values until each lane rewrites its own.
- Start while busy: ignored, start_err pulses, and no captured state changes.
- States:
  - IDLE: waits for an accepted start, then moves to RUN.
  - RUN: lanes count down. Moves to IDLE when all lanes have completed.
- Parallel modes (1, 2, 3): all lanes begin counting at the start edge.
- SEQ mode: lane 0 starts first. Lane k starts at the edge where lane k-1 completes.
- done pulse conditions:
  - SEQ and JOIN_ALL: at the last lane's completion.
  - JOIN_ANY: at the first completion. The remaining lanes keep running and busy stays high.
  - JOIN_NONE: one cycle after start, independent of the lanes. The lanes run in the background.
- JOIN_ANY tie: if several lanes complete on the same edge, first_id is the lowest index among them. done still pulses only once.
- The JOIN_NONE done can coincide with a lane completion. In that case one done pulse is issued.

## Timing
- Let edge T be the edge that accepts start.
- Completion times:
  - Parallel modes: lane i completes at edge T+L_i.
  - SEQ: lane k completes at edge T + L_0 + … + L_k.
- At a lane's completion edge, ch_valid[i] and result_i become visible in the following cycle.
- busy rises after edge T. It falls after the last completion edge, the same edge whose effects show the final ch_valid bit.
- done is high for exactly one cycle, following:
  - JOIN_ALL: edge T+max(L);
  - JOIN_ANY: edge T+min(L);
  - JOIN_NONE: edge T+1;
  - SEQ: edge T+ΣL.
- A new start is accepted on the edge right after busy falls.
- Minimum run-to-run spacing is max(L)+1 cycles for the parallel modes and ΣL+1 cycles for SEQ.

## Test plan
- JOIN_ALL, data_in=0x10, L={1,3,2,5}:
  - result = {0x18,0x14,0x12,0x11} (lane 3 down to lane 0);
  - ch_valid bits set at T+1, T+2, T+3 and T+5;
  - done and busy fall both follow edge T+5.
- JOIN_ANY, L={3,2,2,4}: done follows T+2 with first_id=1; busy stays high until T+4; ch_valid=4'b1111 at the end.
- JOIN_NONE, L={4,4,4,4}: done follows T+1 with ch_valid=0; all four lanes become valid at T+4; no second done pulse.
- SEQ, L={1,3,2,5}: lanes complete at T+1, T+4, T+6 and T+11; done follows T+11.
- Start at T+2 of a JOIN_ALL run: start_err pulses and outputs are unaffected. Separately, rst_n=0 at T+2: all outputs go to 0 asynchronously and no done pulse appears.
- Boundary, data_in=0xFF, L={0,0,0,0}, JOIN_ALL: all lanes complete at T+1 with result0=0x00 (wrap) and result3=0x07.

Source files
------------

// File: rtl/fork_join_engine.sv
// fork_join_engine: CHANNELS-lane fork/join dispatcher with programmable per-lane latency and SEQ/JOIN_ALL/JOIN_ANY/JOIN_NONE completion.
module fork_join_engine #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int LAT_W = 4,
  localparam int ID_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          data_in,
  input  logic [CHANNELS*LAT_W-1:0] lat_in,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           first_id,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic [CHANNELS*WIDTH-1:0] result,
  output logic                      start_err
);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  logic [0:0] state;
  logic [LAT_W-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0] running, comp, nxt_run;
  logic [1:0] mode_q;
  logic [WIDTH-1:0] data_q;
  logic any_seen, none_pend;
  logic [ID_W-1:0] low_id;
  assign busy = state == RUN;
  // In SEQ a finishing lane hands off to the next one; its counter was preloaded at start.
  always_comb begin
    comp = '0;
    low_id = '0;
    for (int i = 0; i < CHANNELS; i++) comp[i] = running[i] && cnt[i] == LAT_W'(1);
    for (int i = CHANNELS - 1; i >= 0; i--) if (comp[i]) low_id = ID_W'(i);
    nxt_run = (running & ~comp) | (mode_q == 2'd0 ? comp << 1 : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      start_err <= 1'b0;
      first_id <= '0;
      ch_valid <= '0;
      result <= '0;
      running <= '0;
      mode_q <= 2'd0;
      data_q <= '0;
      any_seen <= 1'b0;
      none_pend <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      start_err <= start && busy;
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          state <= RUN;
          mode_q <= mode;
          data_q <= data_in;
          ch_valid <= '0;
          running <= mode == 2'd0 ? CHANNELS'(1) : '1;
          any_seen <= 1'b0;
          none_pend <= mode == 2'd3;
          for (int i = 0; i < CHANNELS; i++)
            cnt[i] <= lat_in[i*LAT_W +: LAT_W] == '0 ? LAT_W'(1) : lat_in[i*LAT_W +: LAT_W];
        end
      end else begin
        none_pend <= 1'b0;
        if (none_pend) done <= 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          if (comp[i]) begin
            ch_valid[i] <= 1'b1;
            result[i*WIDTH +: WIDTH] <= data_q + (WIDTH'(1) << i);
          end else if (running[i]) cnt[i] <= cnt[i] - LAT_W'(1);
        end
        running <= nxt_run;
        if (mode_q == 2'd2 && |comp && !any_seen) begin
          done <= 1'b1;
          any_seen <= 1'b1;
          first_id <= low_id;
        end
        if (nxt_run == '0) begin
          state <= IDLE;
          if (mode_q <= 2'd1) done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fork_join_engine.sv
// tb_fork_join_engine: randomized and directed checks against a completion-time model of the fork/join engine.
module tb_fork_join_engine;
  localparam int W = 8, C = 4, LW = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] mode = 0;
  logic [W-1:0] data_in = 0;
  logic [C*LW-1:0] lat_in = 0;
  logic busy, done, start_err;
  logic [1:0] first_id;
  logic [C-1:0] ch_valid;
  logic [C*W-1:0] result;
  fork_join_engine #(.WIDTH(W), .CHANNELS(C), .LAT_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .data_in(data_in), .lat_in(lat_in),
    .busy(busy), .done(done), .first_id(first_id), .ch_valid(ch_valid), .result(result), .start_err(start_err)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, n = 0, dt;
  bit armed = 0;
  int t0 = 0, last_t = 0, done_t = 0;
  int comp_t [C];
  logic [1:0] mode_m = 0, fid_exp = 0, any_id = 0;
  logic [W-1:0] data_m = 0;
  logic [W-1:0] res_exp [C] = '{default: '0};
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s n=%0d actual=%0h required=%0h", name, n, act, exp);
    end
  endtask
  function automatic bit busy_m(int k);
    return armed && k >= t0 && k < last_t;
  endfunction
  task automatic check(bit serr);
    logic [C-1:0] v;
    logic [C*W-1:0] r;
    for (int i = 0; i < C; i++) begin
      if (armed && n >= comp_t[i]) res_exp[i] = data_m + (W'(1) << i);
      v[i] = armed && n >= comp_t[i];
      r[i*W +: W] = res_exp[i];
    end
    if (armed && n == done_t && mode_m == 2'd2) fid_exp = any_id;
    chk("busy", busy, busy_m(n));
    chk("done", done, armed && n == done_t);
    chk("ch_valid", ch_valid, v);
    chk("result", result, r);
    chk("first_id", first_id, fid_exp);
    chk("start_err", start_err, serr);
  endtask
  task automatic model_reset();
    armed = 0;
    fid_exp = 0;
    for (int i = 0; i < C; i++) res_exp[i] = '0;
  endtask
  task automatic step(bit s, logic [1:0] m, logic [W-1:0] d, logic [C*LW-1:0] l);
    bit serr;
    int lat, acc, mn, mx;
    start = s; mode = m; data_in = d; lat_in = l;
    serr = s && busy_m(n) && rst_n;
    if (s && !busy_m(n) && rst_n) begin
      armed = 1; t0 = n + 1; mode_m = m; data_m = d;
      acc = t0; mn = 1 << 30; mx = 0;
      for (int i = 0; i < C; i++) begin
        lat = int'(l[i*LW +: LW]);
        if (lat == 0) lat = 1;
        if (m == 2'd0) begin acc += lat; comp_t[i] = acc; end
        else comp_t[i] = t0 + lat;
        if (comp_t[i] < mn) begin mn = comp_t[i]; any_id = 2'(i); end
        if (comp_t[i] > mx) mx = comp_t[i];
      end
      last_t = mx;
      done_t = m == 2'd3 ? t0 + 1 : m == 2'd2 ? mn : mx;
    end
    @(posedge clk);
    n++;
    @(negedge clk);
    check(serr);
  endtask
  task automatic run(logic [1:0] m, logic [W-1:0] d, logic [C*LW-1:0] l, output int dt_o);
    int ts;
    dt_o = -1;
    step(1, m, d, l);
    ts = t0;
    if (done && dt_o < 0) dt_o = n - ts;
    for (int k = 0; k < 80 && busy_m(n); k++) begin
      step(0, 0, 0, 0);
      if (done && dt_o < 0) dt_o = n - ts;
    end
    step(0, 0, 0, 0);
  endtask
  initial begin
    #2;
    check(0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 0);
    run(2'd1, 8'h10, {4'd5, 4'd2, 4'd3, 4'd1}, dt);
    chk("all_done_time", dt, 5);
    chk("all_result", result, 32'h18141211);
    run(2'd2, 8'h40, {4'd4, 4'd2, 4'd2, 4'd3}, dt);
    chk("any_done_time", dt, 2);
    chk("any_first_id", first_id, 1);
    chk("any_valid_end", ch_valid, 4'b1111);
    run(2'd3, 8'h05, 16'h4444, dt);
    chk("none_done_time", dt, 1);
    run(2'd0, 8'h22, {4'd5, 4'd2, 4'd3, 4'd1}, dt);
    chk("seq_done_time", dt, 11);
    step(1, 2'd1, 8'h20, 16'h4444);
    step(0, 0, 0, 0);
    step(1, 2'd2, 8'h99, 16'h0000);
    chk("start_err_pulse", start_err, 1);
    for (int k = 0; k < 20 && busy_m(n); k++) step(0, 0, 0, 0);
    step(1, 2'd1, 8'h30, 16'h6666);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", ch_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    model_reset();
    #3;
    step(0, 0, 0, 0);
    rst_n = 1;
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    run(2'd1, 8'hFF, 16'h0000, dt);
    chk("wrap_done_time", dt, 1);
    chk("wrap_result", result, 32'h07030100);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), W'($urandom), (C*LW)'($urandom));
    for (int k = 0; k < 80 && busy_m(n); k++) step(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
